// File: rtl/mem_responder.sv
// Byte-addressed memory responder: req/ack handshake, WAIT_CYCLES wait states, word/half/byte access.
// Optional MEM_RESP_ALIGN_CHECK_EN flags misaligned accesses with err instead of forcing alignment.
module mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [7:0]          mem_q [DEPTH];

  logic                go_resp;
  logic                acc_we;
  logic [1:0]          acc_size;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic                is_half, is_byte, is_word;
  logic [ADDR_W-1:0]   base;
  logic                err_flag;
  logic [3:0]          lane_en;
  logic [ADDR_W-1:0]   lane_addr [4];
  logic [31:0]         rd_word, rd_val;
  logic                mem_wr;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d = S_RESP;
          go_resp = 1'b1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the access commits on the accepting edge, before the latches are loaded.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = we;
      acc_size  = size;
      acc_addr  = addr[ADDR_W-1:0];
      acc_wdata = wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign is_half = (acc_size == 2'b01);
  assign is_byte = (acc_size == 2'b10);
  assign is_word = !is_half && !is_byte;
  assign lane_en = is_word ? 4'hF : (is_half ? 4'h3 : 4'h1);

`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign base     = acc_addr;
  assign err_flag = (is_word && (acc_addr[1:0] != 2'b00)) || (is_half && acc_addr[0]);
`else
  assign base     = is_word ? {acc_addr[ADDR_W-1:2], 2'b00} :
                    is_half ? {acc_addr[ADDR_W-1:1], 1'b0}  : acc_addr;
  assign err_flag = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_addr[gi]       = base + ADDR_W'(gi);
      assign rd_word[8*gi +: 8]  = mem_q[lane_addr[gi]];
    end
  endgenerate

  assign rd_val = is_word ? rd_word :
                  is_half ? {16'b0, rd_word[15:0]} : {24'b0, rd_word[7:0]};
  assign mem_wr = go_resp && acc_we && !err_flag;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (go_resp) begin
      err_d = err_flag;
      if (!acc_we && !err_flag) rdata_d = rd_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == S_IDLE && req) begin
        we_q    <= we;
        size_q  <= size;
        addr_q  <= addr[ADDR_W-1:0];
        wdata_q <= wdata;
      end
    end
  end

  // Array is never reset; the rst gate keeps an access from landing while reset is held.
  always_ff @(posedge clk) begin
    if (mem_wr && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem_q[lane_addr[k]] <= acc_wdata[8*k +: 8];
      end
    end
  end

  assign ack   = (state_q == S_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a byte-array reference model, plus a zero-wait instance.
module tb_mem_responder;

  localparam int W     = 1;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        ack, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [1:0]  size0 = 2'b00;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic        ack0, err0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err));

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .err(err0));

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    bit          err;
    bit          we;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [7:0]  mm [DEPTH];
  logic [31:0] model_rdata = 32'd0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          txn_no = 0;
  bit          exp_ack;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: little-endian byte array, zero-extended reads, alignment handled per build.
  function automatic void model_access(input bit w, input logic [1:0] s, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] r, output bit e);
    int nb;
    int b;
    nb = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
    b  = int'(a % DEPTH);
    r  = 32'd0;
    e  = 1'b0;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    if (b % nb != 0) begin
      e = 1'b1;
      return;
    end
`else
    b = b - (b % nb);
`endif
    for (int k = 0; k < nb; k++) begin
      if (w) mm[(b + k) % DEPTH] = d[8*k +: 8];
      r[8*k +: 8] = mm[(b + k) % DEPTH];
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      exp_ack = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("ack", {31'd0, ack}, {31'd0, exp_ack});
      if (exp_ack) begin
        cur = exp_q.pop_front();
        chk("err", {31'd0, err}, {31'd0, cur.err});
        if (!cur.we && !cur.err) model_rdata = cur.rdata;
      end
      chk("rdata", rdata, model_rdata);
    end
  end

  // Called on a negedge with the DUT idle; returns on the negedge after the ack cycle.
  task automatic do_txn(input bit w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r, output logic e);
    exp_t        x;
    logic [31:0] mr;
    bit          me;
    model_access(w, s, a, d, mr, me);
    x.cyc = cyc + 1 + W; x.rdata = mr; x.err = me; x.we = w;
    exp_q.push_back(x);
    req = 1'b1; we = w; size = s; addr = a; wdata = d;
    @(negedge clk);
    req = 1'($urandom); we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
    repeat (W) @(negedge clk);
    r = rdata; e = err; req = 1'b0;
    txn_no++;
    $display("txn %0d we=%0b size=%0d addr=%h wdata=%h -> rdata=%h err=%0b",
             txn_no, w, s, a, d, r, e);
    @(negedge clk);
  endtask

  logic [31:0] r;
  logic        e;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_ack0", {31'd0, ack0}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < DEPTH / 4; i++) do_txn(1'b1, 2'b00, 32'(i * 4), $urandom, r, e);

    // Word write/read and byte-lane patching
    do_txn(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, r, e);
    do_txn(1'b0, 2'b00, 32'h10, 32'h0, r, e);
    chk("t1_rdata", r, 32'hDEADBEEF);
    chk("t1_err", {31'd0, e}, 32'd0);
    do_txn(1'b1, 2'b10, 32'h11, 32'h00000055, r, e);
    do_txn(1'b0, 2'b00, 32'h10, 32'h0, r, e);
    chk("t2_word", r, 32'hDEAD55EF);
    do_txn(1'b0, 2'b01, 32'h12, 32'h0, r, e);
    chk("t2_half", r, 32'h0000DEAD);
    do_txn(1'b0, 2'b10, 32'h13, 32'h0, r, e);
    chk("t2_byte", r, 32'h000000DE);

    // Reset during WAIT aborts the write
    do_txn(1'b1, 2'b00, 32'h20, 32'h11111111, r, e);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h20; wdata = 32'h12345678;
    @(negedge clk);
    req = 1'b0;
    #2 rst = 1'b1;
    model_rdata = 32'd0;
    #1;
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    chk("rst_mid_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 2'b00, 32'h20, 32'h0, r, e);
    checks++;
    if (r === 32'h12345678) begin
      failures++;
      $display("FAIL rst_abort: got %h required not 12345678", r);
    end
    chk("rst_abort_old", r, 32'h11111111);

    // Misaligned word write
    do_txn(1'b1, 2'b00, 32'h22, 32'hAABBCCDD, r, e);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    chk("t5_err", {31'd0, e}, 32'd1);
    do_txn(1'b0, 2'b00, 32'h20, 32'h0, r, e);
    chk("t5_unchanged", r, 32'h11111111);
`else
    chk("t5_err", {31'd0, e}, 32'd0);
    do_txn(1'b0, 2'b00, 32'h20, 32'h0, r, e);
    chk("t5_forced", r, 32'hAABBCCDD);
`endif

    // Address wrap
    do_txn(1'b1, 2'b00, 32'h104, 32'hCAFEF00D, r, e);
    do_txn(1'b0, 2'b00, 32'h04, 32'h0, r, e);
    chk("t6_wrap", r, 32'hCAFEF00D);

    // Zero-wait instance, req held across three transactions
    req0 = 1'b1; we0 = 1'b1; size0 = 2'b00; addr0 = 32'h08; wdata0 = 32'hA5A50F0F;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("t3_ack_%0d", i), {31'd0, ack0}, {31'd0, (i < 5) && (i % 2 == 0)});
      if (i == 4) req0 = 1'b0;
    end
    req0 = 1'b1; we0 = 1'b0;
    @(negedge clk);
    chk("t3_rd_ack", {31'd0, ack0}, 32'd1);
    chk("t3_rd_data", rdata0, 32'hA5A50F0F);
    req0 = 1'b0;
    @(negedge clk);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      do_txn(1'($urandom), 2'($urandom), 32'($urandom_range(0, 1023)), $urandom, r, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
